// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, registers imem words into the IR
// and offers them to decode over a valid/ready handshake.
module fetch_controller #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 16,
  parameter logic [2:0]  HALT_OP  = 3'b111,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [DATA_W-1:0]   ir_n;
  logic [ADDR_W-1:0]   ir_pc_n;
  logic                valid_n;
  logic                is_halt;

  assign is_halt   = (ir[DATA_W-1 -: 3] == HALT_OP);
  assign imem_addr = pc;
  assign busy      = (state == FETCH) || (state == ISSUE);
  assign halted    = (state == HALT);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    ir_pc_n = ir_pc;
    valid_n = ir_valid;
    unique case (state)
      IDLE: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (start) state_n = FETCH;
      end
      FETCH, ISSUE: begin
        // redirect wins over both load and halt detection
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (state == FETCH || ir_ready) begin
          if (state == ISSUE && is_halt) begin
            valid_n = 1'b0;
            state_n = HALT;
          end else begin
            ir_n    = imem_data;
            ir_pc_n = pc;
            pc_n    = pc + ADDR_W'(1);
            valid_n = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected words are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic [9:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        busy;
  logic        halted;

  logic [15:0] mem [1024];
  logic [25:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue: unexpected ir %h pc %0d", ir, ir_pc);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({ir, ir_pc} !== e) begin
          errors++;
          $display("FAIL issue: got ir %h pc %0d, expected ir %h pc %0d",
                   ir, ir_pc, e[25:10], e[9:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [9:0] a);
    exp_q.push_back({w, a});
  endtask

  task automatic push_prog();
    push(16'h2C03, 10'd0);
    push(16'h8180, 10'd1);
    push(16'h2404, 10'd2);
    push(16'h0083, 10'd3);
    push(16'hE000, 10'd4);
  endtask

  task automatic run(input int max, input bit toggle);
    logic        v;
    logic [9:0]  a;
    logic [15:0] w;
    bit          done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      ir_ready = toggle ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
      start    = toggle && (i == 2);
      v = ir_valid;
      a = imem_addr;
      w = ir;
      step();
      if (v && !ir_ready) begin
        chk("hold_ir", ir, w);
        chk("hold_addr", imem_addr, a);
      end
      if (halted) done = 1'b1;
    end
    start = 1'b0;
    chk("run_halted", halted, 1);
    chk("run_valid", ir_valid, 0);
    chk("run_pc", imem_addr, 5);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h2C03;
    mem[1] = 16'h8180;
    mem[2] = 16'h2404;
    mem[3] = 16'h0083;
    mem[4] = 16'hE000;
    mem[1023] = 16'h0123;
    rst_n = 1'b1;
    start = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ir", ir, 0);
    chk("rst_addr", imem_addr, 0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // straight run, ready held high
    push_prog();
    ir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", ir_valid, 0);
    step();
    chk("first_valid", ir_valid, 1);
    chk("first_ir", ir, 16'h2C03);
    chk("first_pc", ir_pc, 0);
    repeat (5) step();
    chk("halt_halted", halted, 1);
    chk("halt_valid", ir_valid, 0);
    chk("halt_pc", imem_addr, 5);
    chk("halt_busy", busy, 0);

    // start ignored in HALT, redirect resumes
    ir_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("halt_start_ign", halted, 1);
    chk("halt_start_pc", imem_addr, 5);
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    step();
    redirect_valid = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_busy", busy, 1);
    chk("resume_valid", ir_valid, 0);

    // toggling ready with a stray start pulse in ISSUE
    push_prog();
    run(60, 1'b1);

    // redirect during an accepted word
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    step();
    redirect_valid = 1'b0;
    push(16'h2C03, 10'd0);
    push(16'h8180, 10'd1);
    push(16'h0083, 10'd3);
    push(16'hE000, 10'd4);
    step();
    chk("rd_first", ir, 16'h2C03);
    step();
    chk("rd_pre", ir, 16'h8180);
    redirect_valid = 1'b1;
    redirect_pc = 10'd3;
    step();
    redirect_valid = 1'b0;
    chk("rd_drop_valid", ir_valid, 0);
    chk("rd_addr", imem_addr, 3);
    step();
    chk("rd_valid", ir_valid, 1);
    chk("rd_ir", ir, 16'h0083);
    chk("rd_pc", ir_pc, 3);
    run(20, 1'b0);

    // async reset mid-ISSUE
    ir_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("pre_rst_valid", ir_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ir_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ir", ir, 0);
    chk("arst_addr", imem_addr, 0);
    #2 rst_n = 1'b1;
    step();

    // wrap from 1023
    redirect_valid = 1'b1;
    redirect_pc = 10'd1023;
    step();
    redirect_valid = 1'b0;
    chk("wrap_idle", busy, 0);
    chk("wrap_addr", imem_addr, 1023);
    push(16'h0123, 10'd1023);
    push_prog();
    ir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("wrap_pc", ir_pc, 1023);
    chk("wrap_next", imem_addr, 0);
    run(20, 1'b0);

    repeat (2) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
